imager_pixel_packer: RTL and testbench

//  Multi-camera pixel collector; successor to the single-camera cam0 pixel FIFO path.

---
 rtl/imager_pixel_packer_pkg.sv | 24 ++
 rtl/imager_pixel_packer_word_fifo.sv | 79 +++++++
 rtl/imager_pixel_packer.sv | 148 ++++++++++++++
 tb/tb_imager_pixel_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imager_pixel_packer_pkg.sv
// Shared width helpers and tag layout for the multi-camera pixel packer.
// Firmware and the bus interface decode rd_tag as {chan, bytes, last}.
package imager_pixel_packer_pkg;

  localparam int TAG_LAST_OFS = 0;
  localparam int TAG_BCNT_OFS = 1;

  function automatic int chid_width(input int num_cams);
    if (num_cams > 1) begin
      return $clog2(num_cams);
    end else begin
      return 1;
    end
  endfunction

  function automatic int bcnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

  function automatic int tag_chid_ofs(input int bcnt_w);
    return TAG_BCNT_OFS + bcnt_w;
  endfunction

endpackage

// File: rtl/imager_pixel_packer_word_fifo.sv
// Synchronous word FIFO with registered read port.
// Status flags are registered from next-state occupancy, so they never lag.
module imager_word_fifo #(
  parameter int W            = 37,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         empty,
  output logic         afull,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [OW-1:0] occ_r, occ_next_s;
  logic [W-1:0]  rd_data_r;
  logic          rd_valid_r, empty_r, afull_r, full_r;
  logic          push_s, pop_s;

  // Accepted push/pop and next occupancy
  always_comb begin
    push_s = wr_en & ~full_r;
    pop_s  = rd_en & ~empty_r;
    if (push_s && !pop_s) begin
      occ_next_s = occ_r + OW'(1);
    end else if (pop_s && !push_s) begin
      occ_next_s = occ_r - OW'(1);
    end else begin
      occ_next_s = occ_r;
    end
  end

  // Pointers, occupancy, flags and read register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      empty_r    <= 1'b1;
      afull_r    <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      rd_valid_r <= pop_s;
      occ_r      <= occ_next_s;
      empty_r    <= (occ_next_s == OW'(0));
      afull_r    <= (occ_next_s >= OW'(AFULL_THRESH));
      full_r     <= (occ_next_s == OW'(DEPTH));
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign empty    = empty_r;
  assign afull    = afull_r;
  assign full     = full_r;

endmodule

// File: rtl/imager_pixel_packer.sv
// Multi-camera pixel packer: per-channel staging, round-robin arbiter and
// shared tagged word FIFO drained by the bus interface.
module imager_pixel_packer
  import imager_pixel_packer_pkg::*;
#(
  parameter int NUM_CAMS     = 2,
  parameter int PIX_W        = 8,
  parameter int WORD_W       = 32,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = 48,
  localparam int PACK        = WORD_W / PIX_W,
  localparam int CHID_W      = chid_width(NUM_CAMS),
  localparam int BCNT_W      = bcnt_width(PACK),
  localparam int TAG_W       = CHID_W + BCNT_W + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CAMS-1:0]       chan_enable,
  input  logic [NUM_CAMS-1:0]       pix_valid,
  input  logic [NUM_CAMS*PIX_W-1:0] pix_data,
  input  logic [NUM_CAMS-1:0]       frame_done,
  output logic [NUM_CAMS-1:0]       pix_ready,
  input  logic                      rd_en,
  output logic [WORD_W-1:0]         rd_data,
  output logic [TAG_W-1:0]          rd_tag,
  output logic                      rd_valid,
  output logic                      fifo_empty,
  output logic                      fifo_afull,
  output logic                      fifo_full,
  output logic [NUM_CAMS-1:0]       overflow,
  input  logic [NUM_CAMS-1:0]       clear_overflow
);

  localparam int EW = WORD_W + TAG_W;

  logic [NUM_CAMS*WORD_W-1:0] acc_flat_s;
  logic [NUM_CAMS*BCNT_W-1:0] cnt_flat_s;
  logic [NUM_CAMS-1:0]        eof_s, pending_s, grant_s;
  logic [NUM_CAMS-1:0]        en_r, overflow_r;
  logic                       grant_vld_s;
  logic [CHID_W-1:0]          grant_idx_s, last_grant_r;
  logic [EW-1:0]              wr_entry_s, rd_entry_s;
  int                         rr_tgt_s;

  for (genvar c = 0; c < NUM_CAMS; c++) begin : g_chan
    logic [WORD_W-1:0] acc_r;
    logic [BCNT_W-1:0] cnt_r;
    logic              eof_r;
    logic              accept_s;

    assign accept_s = pix_valid[c] & pix_ready[c];

    // Staging: disable discards, grant empties, otherwise pack into lane cnt
    always_ff @(posedge clk) begin
      if (reset || !chan_enable[c]) begin
        acc_r <= '0;
        cnt_r <= '0;
        eof_r <= 1'b0;
      end else if (grant_s[c]) begin
        acc_r <= '0;
        cnt_r <= '0;
        eof_r <= frame_done[c];
      end else begin
        if (accept_s) begin
          for (int l = 0; l < PACK; l++) begin
            if (cnt_r == BCNT_W'(l)) acc_r[l*PIX_W +: PIX_W] <= pix_data[c*PIX_W +: PIX_W];
          end
          cnt_r <= cnt_r + BCNT_W'(1);
        end
        if (frame_done[c]) eof_r <= 1'b1;
      end
    end

    assign pix_ready[c] = en_r[c] & (cnt_r < BCNT_W'(PACK)) & ~eof_r;
    assign pending_s[c] = (cnt_r == BCNT_W'(PACK)) | eof_r;
    assign eof_s[c]     = eof_r;
    assign acc_flat_s[c*WORD_W +: WORD_W] = acc_r;
    assign cnt_flat_s[c*BCNT_W +: BCNT_W] = cnt_r;
  end

  // Registered enable keeps pix_ready a function of flops only
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r         <= '0;
      overflow_r   <= '0;
      last_grant_r <= CHID_W'(NUM_CAMS - 1);
    end else begin
      en_r       <= chan_enable;
      overflow_r <= (chan_enable & pix_valid & ~pix_ready) | (overflow_r & ~clear_overflow);
      if (grant_vld_s) last_grant_r <= grant_idx_s;
    end
  end

  // Round-robin search starting after the last granted channel
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    grant_s     = '0;
    rr_tgt_s    = 0;
    for (int i = 1; i <= NUM_CAMS; i++) begin
      rr_tgt_s = (int'(last_grant_r) + i) % NUM_CAMS;
      for (int c = 0; c < NUM_CAMS; c++) begin
        if (!fifo_full && !grant_vld_s && pending_s[c] && (c == rr_tgt_s)) begin
          grant_vld_s = 1'b1;
          grant_idx_s = CHID_W'(c);
          grant_s[c]  = 1'b1;
        end else begin
          grant_s[c] = grant_s[c];
        end
      end
    end
  end

  // Entry for the granted channel: {data, chan, bytes, last}
  always_comb begin
    wr_entry_s = '0;
    for (int c = 0; c < NUM_CAMS; c++) begin
      if (grant_s[c]) begin
        wr_entry_s = {acc_flat_s[c*WORD_W +: WORD_W], CHID_W'(c),
                      cnt_flat_s[c*BCNT_W +: BCNT_W], eof_s[c]};
      end else begin
        wr_entry_s = wr_entry_s;
      end
    end
  end

  imager_word_fifo #(
    .W            (EW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (grant_vld_s),
    .wr_data  (wr_entry_s),
    .rd_en    (rd_en),
    .rd_data  (rd_entry_s),
    .rd_valid (rd_valid),
    .empty    (fifo_empty),
    .afull    (fifo_afull),
    .full     (fifo_full)
  );

  assign rd_data  = rd_entry_s[EW-1:TAG_W];
  assign rd_tag   = rd_entry_s[TAG_W-1:0];
  assign overflow = overflow_r;

endmodule

// File: tb/tb_imager_pixel_packer.sv
// Directed self-checking bench for imager_pixel_packer (2 cameras, 8->32 packing, depth 64).
module tb_imager_pixel_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  chan_enable, pix_valid, frame_done, pix_ready, overflow, clear_overflow;
  logic [15:0] pix_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [4:0]  rd_tag;
  logic        rd_valid, fifo_empty, fifo_afull, fifo_full;
  int          n_tests = 0;
  int          n_fail  = 0;

  imager_pixel_packer dut (
    .clk(clk), .reset(reset), .chan_enable(chan_enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_done(frame_done), .pix_ready(pix_ready), .rd_en(rd_en),
    .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid), .fifo_empty(fifo_empty),
    .fifo_afull(fifo_afull), .fifo_full(fifo_full), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_word(input int ch, input logic [31:0] w);
    for (int l = 0; l < 4; l++) begin
      pix_valid[ch] = 1'b1;
      pix_data[ch*8 +: 8] = w[l*8 +: 8];
      tick();
    end
    pix_valid[ch] = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'(k) * 32'h01010101 + 32'h03020100;
  endfunction

  task automatic test_reset();
    chan_enable = 2'b11;
    reset = 1'b1;
    tick();
    tick();
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", fifo_empty); end
    n_tests++; if (fifo_afull !== 1'b0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull_full: got %b%b want 00", fifo_afull, fifo_full); end
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || rd_tag !== 5'h00) begin n_fail++; $display("FAIL rst_rd: got %b %h %h want 0 0 0", rd_valid, rd_data, rd_tag); end
    n_tests++; if (pix_ready !== 2'b00 || overflow !== 2'b00) begin n_fail++; $display("FAIL rst_ready_ovf: got %b %b want 00 00", pix_ready, overflow); end
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    chan_enable = 2'b01;
    tick();
    n_tests++; if (pix_ready !== 2'b01) begin n_fail++; $display("FAIL t1_ready: got %b want 01", pix_ready); end
    for (int l = 0; l < 4; l++) begin
      pix_valid[0] = 1'b1;
      pix_data[7:0] = 8'h11 * 8'(l + 1);
      tick();
    end
    pix_valid[0] = 1'b0;
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL t1_empty_before_write: got %b want 1", fifo_empty); end
    n_tests++; if (pix_ready[0] !== 1'b0) begin n_fail++; $display("FAIL t1_ready_full_word: got %b want 0", pix_ready[0]); end
    tick();
    n_tests++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL t1_empty_after_write: got %b want 0", fifo_empty); end
    pop();
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== 32'h44332211 || rd_tag !== 5'h08) begin n_fail++; $display("FAIL t1_word: got %b %h %h want 1 44332211 08", rd_valid, rd_data, rd_tag); end
    tick();
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 32'h44332211 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL t1_hold: got %b %h %b want 0 44332211 1", rd_valid, rd_data, fifo_empty); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [7];
    logic [4:0]  exp_t [7];
    apply_reset();
    chan_enable = 2'b11;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      for (int l = 0; l < 4; l++) begin
        pix_valid = 2'b11;
        pix_data[7:0]  = pat(rep*8)[l*8 +: 8];
        pix_data[15:8] = pat(rep*8 + 4)[l*8 +: 8];
        tick();
      end
      pix_valid = 2'b00;
      tick();
      n_tests++; if (pix_ready !== 2'b01) begin n_fail++; $display("FAIL t2_first_grant_ready: got %b want 01", pix_ready); end
      tick();
    end
    send_word(0, pat(40));
    for (int l = 0; l < 4; l++) begin
      pix_valid = 2'b11;
      pix_data[7:0]  = pat(44)[l*8 +: 8];
      pix_data[15:8] = pat(48)[l*8 +: 8];
      tick();
    end
    pix_valid = 2'b00;
    tick();
    tick();
    exp_d = '{pat(0), pat(4), pat(8), pat(12), pat(40), pat(48), pat(44)};
    exp_t = '{5'h08, 5'h18, 5'h08, 5'h18, 5'h08, 5'h18, 5'h08};
    for (int i = 0; i < 7; i++) begin
      pop();
      n_tests++; if (rd_data !== exp_d[i] || rd_tag !== exp_t[i]) begin n_fail++; $display("FAIL t2_order[%0d]: got %h/%h want %h/%h", i, rd_data, rd_tag, exp_d[i], exp_t[i]); end
    end
  endtask

  task automatic test_eof();
    logic [31:0] exp_d [3];
    logic [4:0]  exp_t [3];
    pix_valid[1] = 1'b1; pix_data[15:8] = 8'hAA; tick();
    pix_data[15:8] = 8'hBB; tick();
    pix_valid[1] = 1'b0;
    frame_done[1] = 1'b1; tick(); frame_done[1] = 1'b0;
    n_tests++; if (pix_ready[1] !== 1'b0) begin n_fail++; $display("FAIL t3_ready_eof: got %b want 0", pix_ready[1]); end
    tick();
    n_tests++; if (pix_ready[1] !== 1'b1) begin n_fail++; $display("FAIL t3_ready_after_grant: got %b want 1", pix_ready[1]); end
    frame_done[1] = 1'b1; tick(); frame_done[1] = 1'b0;
    tick();
    pix_valid[1] = 1'b1; pix_data[15:8] = 8'hCC; frame_done[1] = 1'b1; tick();
    pix_valid[1] = 1'b0; frame_done[1] = 1'b0;
    tick();
    exp_d = '{32'h0000BBAA, 32'h00000000, 32'h000000CC};
    exp_t = '{5'h15, 5'h11, 5'h13};
    for (int i = 0; i < 3; i++) begin
      pop();
      n_tests++; if (rd_data !== exp_d[i] || rd_tag !== exp_t[i]) begin n_fail++; $display("FAIL t3_eof[%0d]: got %h/%h want %h/%h", i, rd_data, rd_tag, exp_d[i], exp_t[i]); end
    end
  endtask

  task automatic test_fifo_levels();
    apply_reset();
    chan_enable = 2'b01;
    tick();
    for (int k = 0; k < 47; k++) send_word(0, pat(k));
    n_tests++; if (fifo_afull !== 1'b0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL t5_47_words: got afull %b full %b want 0 0", fifo_afull, fifo_full); end
    send_word(0, pat(47));
    n_tests++; if (fifo_afull !== 1'b1) begin n_fail++; $display("FAIL t5_48th_afull: got %b want 1", fifo_afull); end
    for (int l = 0; l < 4; l++) begin
      pix_valid[0] = 1'b1; pix_data[7:0] = pat(48)[l*8 +: 8]; tick();
    end
    pix_valid[0] = 1'b0;
    pop();
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== pat(0) || fifo_afull !== 1'b1) begin n_fail++; $display("FAIL t5_pop_and_write: got %b %h %b want 1 %h 1", rd_valid, rd_data, fifo_afull, pat(0)); end
    pop();
    n_tests++; if (rd_data !== pat(1) || fifo_afull !== 1'b0) begin n_fail++; $display("FAIL t5_pop_to_47: got %h %b want %h 0", rd_data, fifo_afull, pat(1)); end
    for (int k = 49; k < 65; k++) send_word(0, pat(k));
    n_tests++; if (fifo_full !== 1'b0 || fifo_afull !== 1'b1) begin n_fail++; $display("FAIL t4_63_words: got full %b afull %b want 0 1", fifo_full, fifo_afull); end
    send_word(0, pat(65));
    n_tests++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL t4_full: got %b want 1", fifo_full); end
    send_word(0, pat(66));
    n_tests++; if (pix_ready[0] !== 1'b0 || fifo_full !== 1'b1 || overflow !== 2'b00) begin n_fail++; $display("FAIL t4_held: got ready %b full %b ovf %b want 0 1 00", pix_ready[0], fifo_full, overflow); end
    pix_valid[0] = 1'b1; tick();
    n_tests++; if (overflow !== 2'b01) begin n_fail++; $display("FAIL t4_ovf_set: got %b want 01", overflow); end
    clear_overflow = 2'b01; tick();
    n_tests++; if (overflow !== 2'b01) begin n_fail++; $display("FAIL t4_set_wins: got %b want 01", overflow); end
    pix_valid[0] = 1'b0; tick(); clear_overflow = 2'b00;
    n_tests++; if (overflow !== 2'b00) begin n_fail++; $display("FAIL t4_ovf_clear: got %b want 00", overflow); end
    pop();
    n_tests++; if (fifo_full !== 1'b0 || rd_data !== pat(2)) begin n_fail++; $display("FAIL t4_pop_full: got full %b data %h want 0 %h", fifo_full, rd_data, pat(2)); end
    tick();
    n_tests++; if (fifo_full !== 1'b1 || pix_ready[0] !== 1'b1) begin n_fail++; $display("FAIL t4_resume: got full %b ready %b want 1 1", fifo_full, pix_ready[0]); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    chan_enable = 2'b11;
    tick();
    for (int k = 0; k < 6; k++) send_word(0, pat(100 + k));
    pix_valid[1] = 1'b1; pix_data[15:8] = 8'h55; tick();
    pix_data[15:8] = 8'h66; tick();
    pix_valid[1] = 1'b0;
    pop();
    n_tests++; if (rd_data !== pat(100) || fifo_empty !== 1'b0) begin n_fail++; $display("FAIL t6_pre: got %h %b want %h 0", rd_data, fifo_empty, pat(100)); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (fifo_empty !== 1'b1 || fifo_afull !== 1'b0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL t6_flags: got %b%b%b want 100", fifo_empty, fifo_afull, fifo_full); end
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || rd_tag !== 5'h00 || pix_ready !== 2'b00 || overflow !== 2'b00) begin n_fail++; $display("FAIL t6_outputs: got %b %h %h %b %b want 0 0 0 00 00", rd_valid, rd_data, rd_tag, pix_ready, overflow); end
    tick(); tick(); tick();
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL t6_no_marker: got %b want 1", fifo_empty); end
    pop();
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_empty_read: got %b want 0", rd_valid); end
    send_word(1, 32'hDEADBEEF);
    pop();
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF || rd_tag !== 5'h18) begin n_fail++; $display("FAIL t6_fresh_word: got %b %h %h want 1 deadbeef 18", rd_valid, rd_data, rd_tag); end
  endtask

  initial begin
    reset = 1'b0;
    chan_enable = 2'b00;
    pix_valid = 2'b00;
    pix_data = 16'h0000;
    frame_done = 2'b00;
    clear_overflow = 2'b00;
    rd_en = 1'b0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_eof();
    test_fifo_levels();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
